noc_flit_tx: RTL
================

// Module: noc_flit_tx
// PURPOSE
//  Read-side drain for gp_fifo. Pops words from a first-word-fall-through FIFO and sends them as flits
//  on a NoC link with a valid/ready handshake. The first word of each packet is a header that carries
//  the payload length. The block marks head and tail flits and counts completed packets.
// PARAMETERS
//  DWIDTH    32  word/flit width; must equal the FIFO data width
//  LEN_BITS  8   header length field width, header[LEN_BITS-1:0] = payload word count (0..2^LEN_BITS-1)
//  CNT_BITS  16  width of the completed-packet counter
// PORTS
//  clk         in   1         clock; all state updates on rising edge
//  reset       in   1         asynchronous, active-low reset (reset==0 clears all state)
//  tx_en       in   1         permits the start of a new packet; sampled only in IDLE
//  fifo_empty  in   1         FIFO empty flag
//  fifo_data   in   DWIDTH    FIFO head word; valid whenever fifo_empty==0
//  fifo_rd_en  out  1         pop request to the FIFO (combinational)
//  flit_valid  out  1         output flit valid
//  flit_ready  in   1         downstream accepts the flit when valid&&ready at a rising edge
//  flit_data   out  DWIDTH    flit payload (the header word passes through unmodified)
//  flit_head   out  1         flit is a packet header
//  flit_tail   out  1         flit is the last flit of its packet
//  busy        out  1         state!=IDLE or flit_valid
//  pkt_count   out  CNT_BITS  number of tail flits accepted downstream; wraps modulo 2^CNT_BITS
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, rem=0, flit_valid=0, flit_data=0, flit_head=0, flit_tail=0,
//   pkt_count=0, so busy=0. fifo_rd_en=0 while reset is asserted.
//  Output register: slot_free = ~flit_valid | flit_ready.
//  fifo_rd_en = ~fifo_empty & slot_free & (state==BODY | tx_en). It is never asserted when fifo_empty=1.
//  On a pop, flit_data<=fifo_data and flit_valid<=1 at the same edge. Latency is 1 cycle from pop to valid.
//   With ready held high, throughput is 1 flit per cycle.
//  If slot_free=1 and there is no pop: flit_valid<=0, and data/head/tail hold their last values.
//  If valid=1 and ready=0: data, head and tail stay stable and there is no pop (backpressure).
//  FSM
//   IDLE: a popped word is a header. Let L=fifo_data[LEN_BITS-1:0]. Load head=1 and tail=(L==0).
//    If L!=0: rem<=L and go to BODY. Otherwise stay in IDLE (a single head+tail flit).
//   BODY: a popped word is payload. Load head=0 and tail=(rem==1), then rem<=rem-1.
//    When rem==1, go to IDLE.
//   With no pop, the state and rem hold.
//  The FIFO running empty mid-packet is legal. flit_valid drops once the last flit is accepted, the
//   block stays in BODY, and it resumes when data arrives. This is not an error.
//  tx_en=0 blocks only new headers. A packet in progress always completes.
//  pkt_count increments by 1 on each edge where flit_valid&flit_ready&flit_tail.
//  Reset mid-packet aborts the packet immediately with no tail. The FIFO is reset separately.
//  Header bits above LEN_BITS are opaque and forwarded unchanged. rem is LEN_BITS wide.
// TESTING
//  1 Hold reset=0 with a non-empty FIFO -> all outputs 0, fifo_rd_en=0. Release -> IDLE, busy=0.
//  2 FIFO {0x0000_0002,0xA,0xB}, ready=1, tx_en=1 -> flits hdr/A/B on 3 consecutive cycles;
//    head on hdr only, tail on B only; pkt_count=1, busy=0 after.
//  3 Same packet with ready=0 for 3 cycles while hdr valid -> hdr held stable, fifo_rd_en=0;
//    A follows the cycle after ready rises.
//  4 Header 0x1234_5600 (L=0) -> one flit 0x1234_5600 with head=1 and tail=1; pkt_count+1; state stays IDLE.
//  5 Header L=3 with only 1 payload word present -> after it is accepted, valid=0 and busy=1;
//    push 2 words -> both sent, tail on the 3rd payload word.
//  6 tx_en drops after the header of an L=2 packet -> both payload flits still sent;
//    the next queued header is not popped until tx_en=1.
//    Also check L=255 (rem full width) and pkt_count wrap 0xFFFF->0.

Source files
------------

// File: rtl/noc_flit_tx.sv
// Drains a first-word-fall-through FIFO onto a NoC link and marks head/tail flits.
// The first popped word of a packet is a header whose low LEN_BITS give the payload length.
module noc_flit_tx #(
    parameter int DWIDTH   = 32,
    parameter int LEN_BITS = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_en,
    input  logic                fifo_empty,
    input  logic [DWIDTH-1:0]   fifo_data,
    output logic                fifo_rd_en,
    output logic                flit_valid,
    input  logic                flit_ready,
    output logic [DWIDTH-1:0]   flit_data,
    output logic                flit_head,
    output logic                flit_tail,
    output logic                busy,
    output logic [CNT_BITS-1:0] pkt_count,
    output logic                state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam logic [LEN_BITS-1:0] REM_ONE = LEN_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_t                state_q;
    logic [LEN_BITS-1:0]   rem_q;
    logic                  valid_q;
    logic [DWIDTH-1:0]     data_q;
    logic                  head_q;
    logic                  tail_q;
    logic [CNT_BITS-1:0]   cnt_q;

    logic                  slot_free;
    logic                  pop;
    logic [LEN_BITS-1:0]   hdr_len;

    // Handshake: a flit transfers on a rising edge where flit_valid && flit_ready.
    // Once valid is high, data/head/tail stay put until that transfer happens.
    assign hdr_len   = fifo_data[LEN_BITS-1:0];
    assign slot_free = ~valid_q | flit_ready;
    assign pop       = reset & ~fifo_empty & slot_free & ((state_q == BODY) | tx_en);

    assign fifo_rd_en = pop;
    assign flit_valid = valid_q;
    assign flit_data  = data_q;
    assign flit_head  = head_q;
    assign flit_tail  = tail_q;
    assign pkt_count  = cnt_q;
    assign busy       = (state_q != IDLE) | valid_q;
    assign state_dbg  = (state_q == BODY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (valid_q && flit_ready && tail_q) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (pop) begin
                valid_q <= 1'b1;
                data_q  <= fifo_data;
                if (state_q == IDLE) begin
                    head_q <= 1'b1;
                    tail_q <= (hdr_len == '0);
                    if (hdr_len != '0) begin
                        rem_q   <= hdr_len;
                        state_q <= BODY;
                    end
                end else begin
                    head_q <= 1'b0;
                    tail_q <= (rem_q == REM_ONE);
                    rem_q  <= rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_q <= IDLE;
                    end
                end
            end else if (slot_free) begin
                // Slot drained with nothing to refill it; payload fields keep their last values.
                valid_q <= 1'b0;
            end
        end
    end

endmodule
